// File: rtl/apb_slave_pkg.sv
// Shared definitions for the APB register completer: FSM encoding, register map indices, defaults.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package apb_slave_pkg;

    // Two-state APB completer FSM; ACCESS covers the wait-state and completion cycles.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Register map word indices.
    localparam int IDX_ID       = 0;
    localparam int IDX_STATUS   = 1;
    localparam int IDX_SCRATCH0 = 2;

    // Constant returned from the ID register unless overridden at instantiation.
    localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA5B0_0001;

    // Wait counter holds 0..15 wait states.
    localparam int CNT_W = 4;

    // Internal register index width, enough for the 64-register maximum.
    localparam int IDX_W = 6;

endpackage

// File: rtl/apb_regfile.sv
// Scratch register storage with per-byte write enables and a combinational read port.
// Latency: write lands on the clock edge with i_we=1; read data is combinational from i_ridx.
// Backpressure: none; the caller only raises i_we on a committing APB edge.
module apb_regfile
    import apb_slave_pkg::*;
#(
    parameter int DEPTH = 6,
    parameter int DW    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [3:0]       i_wbe,
    input  logic [DW-1:0]    i_wdata,
    input  logic [IDX_W-1:0] i_ridx,
    output logic [DW-1:0]    o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Byte-lane writes into the addressed entry; everything clears on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_widx == IDX_W'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (i_wbe[b]) begin
                            r_mem[i][8*b +: 8] <= i_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read mux; an index outside the storage returns zero.
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_ridx == IDX_W'(i)) begin
                o_rdata = r_mem[i];
            end
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 completer with ID/STATUS/scratch registers, PCLKEN-qualified; optional byte strobes via APB4_PSTRB_EN.
// Latency: 2 + WAIT_STATES enabled cycles per transfer; PRDATA registered at the setup edge.
// Backpressure: PREADY held low for WAIT_STATES enabled access cycles; PSLVERR flags illegal accesses.
module apb_reg_slave
    import apb_slave_pkg::*;
#(
    parameter int          ADDRWIDTH   = 16,
    parameter int          DATAWIDTH   = 32,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 PCLKEN,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic                 PWRITE,
    input  logic [DATAWIDTH-1:0] PWDATA,
`ifdef APB4_PSTRB_EN
    input  logic [3:0]           PSTRB,
`endif
    output logic [DATAWIDTH-1:0] PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR
);

    // Word index as presented on the bus; ADDRWIDTH must cover at least IDX_W + 2 bits.
    localparam int AIDX_W = ADDRWIDTH - 2;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_write;
    logic                   r_err;
    logic [DATAWIDTH-1:0]   r_wdata;
    logic [3:0]             r_strb;
    logic [15:0]            r_err_cnt;
    logic [15:0]            r_wr_cnt;
    logic [DATAWIDTH-1:0]   r_prdata;

    logic [AIDX_W-1:0]      w_addr_idx;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_range_err;
    logic                   w_ro_hit;
    logic                   w_err;
    logic [3:0]             w_strb_in;
    logic                   w_setup;
    logic                   w_done;
    logic                   w_commit_wr;
    logic [DATAWIDTH-1:0]   w_status;
    logic [DATAWIDTH-1:0]   w_rf_rdata;
    logic [DATAWIDTH-1:0]   w_rd_val;
    logic                   w_ready;

    assign w_addr_idx  = PADDR[ADDRWIDTH-1:2];
    assign w_idx       = w_addr_idx[IDX_W-1:0];
    // Range check uses the full bus index so high address bits cannot alias into the map.
    assign w_range_err = (w_addr_idx >= AIDX_W'(NUM_REGS));
    assign w_ro_hit    = PWRITE && ((w_idx == IDX_W'(IDX_ID)) || (w_idx == IDX_W'(IDX_STATUS)));
    assign w_err       = (PADDR[1:0] != 2'b00) || w_range_err || w_ro_hit;

`ifdef APB4_PSTRB_EN
    assign w_strb_in = PSTRB;
`else
    assign w_strb_in = 4'hF;
`endif

    // Setup phase is only honoured from IDLE; a stray PENABLE=1 there is ignored.
    assign w_setup     = PCLKEN && (r_state == IDLE) && PSEL && !PENABLE;
    // Completion needs PSEL still high; a deselect in ACCESS aborts without commit.
    assign w_done      = PCLKEN && (r_state == ACCESS) && PSEL && (r_cnt == '0);
    assign w_commit_wr = w_done && r_write && !r_err;
    assign w_status    = {r_err_cnt, r_wr_cnt};

    apb_regfile #(
        .DEPTH (NUM_REGS - IDX_SCRATCH0),
        .DW    (DATAWIDTH)
    ) u_regfile (
        .i_clk   (HCLK),
        .i_rst_n (HRESETn),
        .i_we    (w_commit_wr),
        .i_widx  (r_idx - IDX_W'(IDX_SCRATCH0)),
        .i_wbe   (r_strb),
        .i_wdata (r_wdata),
        .i_ridx  (w_idx - IDX_W'(IDX_SCRATCH0)),
        .o_rdata (w_rf_rdata)
    );

    // Read value for the address currently on the bus: ID and STATUS live here, the rest in the regfile.
    always_comb begin
        w_rd_val = w_rf_rdata;
        if (w_idx == IDX_W'(IDX_ID)) begin
            w_rd_val = ID_VALUE;
        end else if (w_idx == IDX_W'(IDX_STATUS)) begin
            w_rd_val = w_status;
        end
    end

    // FSM state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: enter ACCESS on setup, leave on completion or deselect.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_setup) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (PCLKEN && (!PSEL || (r_cnt == '0))) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs: ready once the wait counter drains, error only alongside ready.
    always_comb begin
        w_ready = (r_state == ACCESS) && (r_cnt == '0);
        PREADY  = w_ready;
        PSLVERR = w_ready && r_err;
    end

    assign PRDATA = r_prdata;

    // Transfer capture at setup and wait-state countdown during ACCESS.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_idx    <= '0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
            r_strb   <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_prdata <= '0;
        end else if (w_setup) begin
            r_idx    <= w_idx;
            r_write  <= PWRITE;
            r_wdata  <= PWDATA;
            r_strb   <= w_strb_in;
            r_err    <= w_err;
            r_cnt    <= CNT_W'(WAIT_STATES);
            r_prdata <= (!PWRITE && !w_err) ? w_rd_val : '0;
        end else if (PCLKEN && (r_state == ACCESS) && PSEL && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Completion counters feeding STATUS; both wrap naturally at 16 bits.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_err_cnt <= '0;
            r_wr_cnt  <= '0;
        end else if (w_done) begin
            if (r_err) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end else if (r_write) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: three instances with WAIT_STATES 0, 3 and 2 share the APB bus.
// Latency: checks PREADY wait counts per transfer in enabled cycles.
// Backpressure: exercised through PREADY wait states, PCLKEN gating, deselect abort and async reset.
module tb_apb_reg_slave;

    logic        HCLK;
    logic        HRESETn;
    logic        PCLKEN;
    logic        PENABLE;
    logic        PWRITE;
    logic [15:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  psel;
    logic        div2;

    wire  [31:0] prdata0, prdata1, prdata2;
    wire         pready0, pready1, pready2;
    wire         pslverr0, pslverr1, pslverr2;

    int n_vec = 0;
    int n_err = 0;

    // Instance 0: WAIT_STATES=0, instance 1: WAIT_STATES=3, instance 2: WAIT_STATES=2.
    apb_reg_slave #(.WAIT_STATES(0)) u_ws0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN), .PSEL(psel[0]), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
`ifdef APB4_PSTRB_EN
        .PSTRB(PSTRB),
`endif
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));

    apb_reg_slave #(.WAIT_STATES(3)) u_ws3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN), .PSEL(psel[1]), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
`ifdef APB4_PSTRB_EN
        .PSTRB(PSTRB),
`endif
        .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1));

    apb_reg_slave #(.WAIT_STATES(2)) u_ws2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN), .PSEL(psel[2]), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
`ifdef APB4_PSTRB_EN
        .PSTRB(PSTRB),
`endif
        .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2));

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // PCLKEN is either always high or toggles so every second rising edge is enabled.
    initial begin
        PCLKEN = 1'b1;
        forever begin
            @(negedge HCLK);
            PCLKEN = div2 ? ~PCLKEN : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic rdy(input int inst);
        case (inst)
            0: return pready0;
            1: return pready1;
            default: return pready2;
        endcase
    endfunction

    function automatic logic slv(input int inst);
        case (inst)
            0: return pslverr0;
            1: return pslverr1;
            default: return pslverr2;
        endcase
    endfunction

    function automatic logic [31:0] rdv(input int inst);
        case (inst)
            0: return prdata0;
            1: return prdata1;
            default: return prdata2;
        endcase
    endfunction

    // Advance to just after the next rising edge on which PCLKEN is high.
    task automatic en_edge();
        @(posedge HCLK);
        while (PCLKEN !== 1'b1) @(posedge HCLK);
        #1;
    endtask

    // One APB transfer; returns read data and error sampled at PREADY, and the wait-cycle count.
    task automatic xfer(input int inst, input logic wr, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rdata, output logic err, output int waits);
        logic done;
        psel    = 3'b001 << inst;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        PSTRB   = strb;
        rdata   = '0;
        err     = 1'b0;
        waits   = 0;
        done    = 1'b0;
        en_edge();
        PENABLE = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            if (rdy(inst) === 1'b1) begin
                rdata = rdv(inst);
                err   = slv(inst);
                done  = 1'b1;
            end else begin
                waits++;
            end
            en_edge();
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL xfer_timeout: inst %0d addr %h got no PREADY, required PREADY within 40 cycles", inst, addr);
        end
        PENABLE = 1'b0;
        psel    = 3'b000;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        er;
        int          w;
        n_vec++;
        if (pready0 !== 1'b0 || pready1 !== 1'b0 || pready2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pready: got %b%b%b required 000", pready0, pready1, pready2);
        end
        n_vec++;
        if (pslverr0 !== 1'b0 || pslverr1 !== 1'b0 || pslverr2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pslverr: got %b%b%b required 000", pslverr0, pslverr1, pslverr2);
        end
        n_vec++;
        if (prdata0 !== 32'h0 || prdata1 !== 32'h0 || prdata2 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_prdata: got %h %h %h required 0", prdata0, prdata1, prdata2);
        end
        xfer(0, 1'b0, 16'h0004, 32'h0, 4'hF, rd, er, w);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL reset_status: got %h required %h", rd, 32'h0);
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        logic        er;
        int          w;
        xfer(0, 1'b1, 16'h0008, 32'hDEADBEEF, 4'hF, rd, er, w);
        n_vec++;
        if (w !== 0 || er !== 1'b0) begin
            n_err++;
            $display("FAIL basic_wr: waits %0d err %b required waits 0 err 0", w, er);
        end
        xfer(0, 1'b0, 16'h0008, 32'h0, 4'hF, rd, er, w);
        n_vec++;
        if (w !== 0 || er !== 1'b0) begin
            n_err++;
            $display("FAIL basic_rd_timing: waits %0d err %b required waits 0 err 0", w, er);
        end
        n_vec++;
        if (rd !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL basic_rd_data: got %h required %h", rd, 32'hDEADBEEF);
        end
        xfer(0, 1'b0, 16'h0004, 32'h0, 4'hF, rd, er, w);
        n_vec++;
        if (rd !== 32'h0000_0001) begin
            n_err++;
            $display("FAIL basic_status: got %h required %h", rd, 32'h0000_0001);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        logic        er;
        int          w;
        xfer(1, 1'b0, 16'h0000, 32'h0, 4'hF, rd, er, w);
        n_vec++;
        if (w !== 3) begin
            n_err++;
            $display("FAIL ws3_waits: got %0d required 3", w);
        end
        n_vec++;
        if (rd !== 32'hA5B0_0001 || er !== 1'b0) begin
            n_err++;
            $display("FAIL ws3_id: got %h err %b required %h err 0", rd, er, 32'hA5B0_0001);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          w;
        xfer(0, 1'b1, 16'h0004, 32'h1234_5678, 4'hF, rd, er, w);
        n_vec++;
        if (er !== 1'b1) begin
            n_err++;
            $display("FAIL err_wr_status: got err %b required 1", er);
        end
        xfer(0, 1'b0, 16'h0040, 32'h0, 4'hF, rd, er, w);
        n_vec++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_err++;
            $display("FAIL err_rd_range: got err %b data %h required err 1 data 0", er, rd);
        end
        xfer(0, 1'b1, 16'h0009, 32'hFFFF_FFFF, 4'hF, rd, er, w);
        n_vec++;
        if (er !== 1'b1) begin
            n_err++;
            $display("FAIL err_wr_misalign: got err %b required 1", er);
        end
        xfer(0, 1'b0, 16'h0008, 32'h0, 4'hF, rd, er, w);
        n_vec++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            n_err++;
            $display("FAIL err_scratch_kept: got %h err %b required %h err 0", rd, er, 32'hDEADBEEF);
        end
        xfer(0, 1'b0, 16'h0004, 32'h0, 4'hF, rd, er, w);
        n_vec++;
        if (rd !== 32'h0003_0001) begin
            n_err++;
            $display("FAIL err_status: got %h required %h", rd, 32'h0003_0001);
        end
        xfer(0, 1'b0, 16'h0020, 32'h0, 4'hF, rd, er, w);
        n_vec++;
        if (er !== 1'b1) begin
            n_err++;
            $display("FAIL err_first_past_end: got err %b required 1", er);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd_a, rd_b, rd_c;
        logic        er_a, er_b, er_c;
        int          w;
        xfer(0, 1'b1, 16'h0010, 32'h1111_1111, 4'hF, rd_a, er_a, w);
        xfer(0, 1'b1, 16'h001C, 32'h2222_2222, 4'hF, rd_a, er_a, w);
        xfer(0, 1'b0, 16'h0010, 32'h0, 4'hF, rd_a, er_a, w);
        xfer(0, 1'b0, 16'h001C, 32'h0, 4'hF, rd_b, er_b, w);
        xfer(0, 1'b0, 16'h0004, 32'h0, 4'hF, rd_c, er_c, w);
        n_vec++;
        if (rd_a !== 32'h1111_1111 || er_a !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_rd_10: got %h err %b required %h err 0", rd_a, er_a, 32'h1111_1111);
        end
        n_vec++;
        if (rd_b !== 32'h2222_2222 || er_b !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_rd_last_reg: got %h err %b required %h err 0", rd_b, er_b, 32'h2222_2222);
        end
        n_vec++;
        if (rd_c !== 32'h0004_0003) begin
            n_err++;
            $display("FAIL b2b_status: got %h required %h", rd_c, 32'h0004_0003);
        end
    endtask

    task automatic test_clken();
        logic [31:0] rd;
        logic        er;
        int          w;
        div2 = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        xfer(2, 1'b0, 16'h0000, 32'h0, 4'hF, rd, er, w);
        n_vec++;
        if (w !== 2 || rd !== 32'hA5B0_0001) begin
            n_err++;
            $display("FAIL clken_rd: waits %0d data %h required waits 2 data %h", w, rd, 32'hA5B0_0001);
        end
        xfer(2, 1'b1, 16'h0008, 32'hCAFE_F00D, 4'hF, rd, er, w);
        n_vec++;
        if (w !== 2 || er !== 1'b0) begin
            n_err++;
            $display("FAIL clken_wr: waits %0d err %b required waits 2 err 0", w, er);
        end
        xfer(2, 1'b0, 16'h0008, 32'h0, 4'hF, rd, er, w);
        n_vec++;
        if (rd !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL clken_readback: got %h required %h", rd, 32'hCAFE_F00D);
        end
        // Setup edge, then one disabled edge: PREADY must stay low and not advance.
        psel = 3'b100; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 16'h0000;
        en_edge();
        PENABLE = 1'b1;
        @(posedge HCLK);
        #1;
        n_vec++;
        if (PCLKEN !== 1'b0 || pready2 !== 1'b0) begin
            n_err++;
            $display("FAIL clken_freeze: pclken %b pready %b required 0 0", PCLKEN, pready2);
        end
        psel = 3'b000; PENABLE = 1'b0;
        en_edge();
        div2 = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        logic        er;
        int          w;
        psel = 3'b001; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0018; PWDATA = 32'h7777_7777; PSTRB = 4'hF;
        en_edge();
        n_vec++;
        if (pready0 !== 1'b1) begin
            n_err++;
            $display("FAIL abort_in_access: pready %b required 1", pready0);
        end
        psel = 3'b000;
        en_edge();
        n_vec++;
        if (pready0 !== 1'b0) begin
            n_err++;
            $display("FAIL abort_to_idle: pready %b required 0", pready0);
        end
        xfer(0, 1'b0, 16'h0018, 32'h0, 4'hF, rd, er, w);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL abort_no_commit: got %h required 0", rd);
        end
        xfer(0, 1'b0, 16'h0004, 32'h0, 4'hF, rd, er, w);
        n_vec++;
        if (rd !== 32'h0004_0003) begin
            n_err++;
            $display("FAIL abort_status: got %h required %h", rd, 32'h0004_0003);
        end
    endtask

`ifdef APB4_PSTRB_EN
    task automatic test_pstrb();
        logic [31:0] rd;
        logic        er;
        int          w;
        xfer(0, 1'b1, 16'h0014, 32'hFFFF_FFFF, 4'hF, rd, er, w);
        xfer(0, 1'b1, 16'h0014, 32'h1234_5678, 4'b0101, rd, er, w);
        xfer(0, 1'b0, 16'h0014, 32'h0, 4'hF, rd, er, w);
        n_vec++;
        if (rd !== 32'hFF34_FF78) begin
            n_err++;
            $display("FAIL pstrb_merge: got %h required %h", rd, 32'hFF34_FF78);
        end
        xfer(0, 1'b1, 16'h0014, 32'h0, 4'b0000, rd, er, w);
        xfer(0, 1'b0, 16'h0004, 32'h0, 4'hF, rd, er, w);
        n_vec++;
        if (rd !== 32'h0004_0006) begin
            n_err++;
            $display("FAIL pstrb_status: got %h required %h", rd, 32'h0004_0006);
        end
    endtask
`endif

    task automatic test_async_reset();
        logic [31:0] rd;
        logic        er;
        int          w;
        psel = 3'b001; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h000C; PWDATA = 32'h0000_0055; PSTRB = 4'hF;
        en_edge();
        PENABLE = 1'b1;
        n_vec++;
        if (pready0 !== 1'b1) begin
            n_err++;
            $display("FAIL arst_pre: pready %b required 1", pready0);
        end
        #1;
        HRESETn = 1'b0;
        #1;
        n_vec++;
        if (pready0 !== 1'b0 || prdata0 !== 32'h0) begin
            n_err++;
            $display("FAIL arst_immediate: pready %b prdata %h required 0 0", pready0, prdata0);
        end
        psel = 3'b000; PENABLE = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        en_edge();
        xfer(0, 1'b0, 16'h000C, 32'h0, 4'hF, rd, er, w);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL arst_write_lost: got %h required 0", rd);
        end
        xfer(0, 1'b0, 16'h0004, 32'h0, 4'hF, rd, er, w);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL arst_status: got %h required 0", rd);
        end
        xfer(0, 1'b0, 16'h0008, 32'h0, 4'hF, rd, er, w);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL arst_scratch_cleared: got %h required 0", rd);
        end
    endtask

    initial begin
        div2    = 1'b0;
        HRESETn = 1'b0;
        psel    = 3'b000;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        PSTRB   = 4'hF;
        repeat (3) @(posedge HCLK);
        #1;
        test_reset_pre();
        @(negedge HCLK);
        HRESETn = 1'b1;
        en_edge();
        test_reset();
        test_basic();
        test_wait_states();
        test_errors();
        test_back_to_back();
        test_clken();
        test_abort();
`ifdef APB4_PSTRB_EN
        test_pstrb();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Outputs while reset is still asserted.
    task automatic test_reset_pre();
        n_vec++;
        if (pready0 !== 1'b0 || pslverr0 !== 1'b0 || prdata0 !== 32'h0) begin
            n_err++;
            $display("FAIL in_reset_outputs: pready %b pslverr %b prdata %h required 0 0 0", pready0, pslverr0, prdata0);
        end
    endtask

endmodule
